execute_unit_mc: RTL and testbench

Parametrised successor to the single-cycle execute stage. It performs single-cycle ALU operations plus an iterative multi-cycle multiply. Operand forwarding comes from its own output register and from write-back. The block has a valid/ready handshake on both sides, so decode can be stalled and downstream back-pressure honoured, plus a synchronous flush. It sits between the decode/register-read buffer and the memory stage.

---
 rtl/execute_unit_mc_if.sv | 44 ++++
 rtl/execute_unit_mc.sv | 219 +++++++++++++++++++++
 tb/tb_execute_unit_mc.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_unit_mc_if.sv
// Handshake bundle between the decode buffer, the execute stage and the memory stage.
// The master drives instructions, write-back and back-pressure; the slave returns results.
interface execute_unit_mc_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int SH_W   = $clog2(DATA_W)
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [REG_AW-1:0] rs_a;
  logic [REG_AW-1:0] rs_b;
  logic              use_imm;
  logic [DATA_W-1:0] imm;
  logic [SH_W-1:0]   shamt;
  logic [REG_AW-1:0] rd;
  logic              reg_write;
  logic              flag_en;
  logic              flush;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] result_hi;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic [2:0]        flags;

  modport master (
    output in_valid, op, src_a, src_b, rs_a, rs_b, use_imm, imm, shamt, rd,
           reg_write, flag_en, flush, wb_rd, wb_reg_write, wb_data, out_ready,
    input  in_ready, out_valid, result, result_hi, out_rd, out_reg_write, flags
  );

  modport slave (
    input  in_valid, op, src_a, src_b, rs_a, rs_b, use_imm, imm, shamt, rd,
           reg_write, flag_en, flush, wb_rd, wb_reg_write, wb_data, out_ready,
    output in_ready, out_valid, result, result_hi, out_rd, out_reg_write, flags
  );
endinterface

// File: rtl/execute_unit_mc.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier, with operand
// forwarding, valid/ready handshaking on both sides and a synchronous flush.
module execute_unit_mc #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input logic              clk,
  input logic              reset,
  execute_unit_mc_if.slave bus
);
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_MOV = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [SH_W-1:0]     cnt_reg;
  logic [2*DATA_W-1:0] mcand_reg;
  logic [2*DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0]   mplier_reg;
  logic [REG_AW-1:0]   mul_rd_reg;
  logic                mul_rw_reg;
  logic                mul_fe_reg;

  logic                out_valid_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [DATA_W-1:0]   result_hi_reg;
  logic [REG_AW-1:0]   out_rd_reg;
  logic                out_rw_reg;
  logic [2:0]          flags_reg;

  logic                slot_free;
  logic                in_ready;
  logic                accept;
  logic                accept_alu;
  logic                accept_mul;
  logic                mul_step;
  logic                mul_last;
  logic                load_mul;

  logic [1:0][DATA_W-1:0] src_arr;
  logic [1:0][REG_AW-1:0] rs_arr;
  logic [1:0][DATA_W-1:0] fwd_arr;
  logic [DATA_W-1:0]      op_a;
  logic [DATA_W-1:0]      op_b;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_nop;
  logic [DATA_W:0]     wide;

  assign slot_free  = !out_valid_reg || bus.out_ready;
  assign accept     = bus.in_valid && in_ready && !bus.flush;
  assign accept_mul = accept && (bus.op == OP_MUL);
  assign accept_alu = accept && (bus.op != OP_MUL);
  assign mul_last   = (cnt_reg == SH_W'(DATA_W - 1));

  assign src_arr[0] = bus.src_a;
  assign src_arr[1] = bus.src_b;
  assign rs_arr[0]  = bus.rs_a;
  assign rs_arr[1]  = bus.rs_b;

  // Own output register beats write-back, which beats the register file.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_arr[gi] =
        (out_valid_reg && out_rw_reg && (out_rd_reg == rs_arr[gi])) ? result_reg :
        (bus.wb_reg_write && (bus.wb_rd == rs_arr[gi]))             ? bus.wb_data :
                                                                      src_arr[gi];
    end
  endgenerate

  assign op_a = fwd_arr[0];
  assign op_b = bus.use_imm ? bus.imm : fwd_arr[1];

  always_comb begin : alu
    alu_res = '0;
    alu_c   = flags_reg[2];
    alu_nop = 1'b0;
    wide    = '0;
    case (bus.op)
      OP_NOT: alu_res = ~op_a;
      OP_INC: begin
        wide    = {1'b0, op_a} + (DATA_W + 1)'(1);
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_DEC: begin
        alu_res = op_a - DATA_W'(1);
        alu_c   = (op_a == '0);
      end
      OP_ADD: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_c   = (op_a < op_b);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      // The extra bit on each shift captures the last bit pushed out.
      OP_SHL: begin
        wide    = {1'b0, op_a} << bus.shamt;
        alu_res = wide[DATA_W-1:0];
        if (bus.shamt != '0) alu_c = wide[DATA_W];
      end
      OP_SHR: begin
        wide    = {op_a, 1'b0} >> bus.shamt;
        alu_res = wide[DATA_W:1];
        if (bus.shamt != '0) alu_c = wide[0];
      end
      OP_MOV: alu_res = op_a;
      OP_MUL: alu_res = '0;
      default: alu_nop = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : fsm_state
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin : fsm_next
    state_next = state_reg;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept_mul) state_next = BUSY;
        BUSY:    if (mul_last)   state_next = DONE;
        DONE:    if (slot_free)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin : fsm_out
    in_ready = reset && (state_reg == IDLE) && slot_free;
    mul_step = (state_reg == BUSY);
    load_mul = (state_reg == DONE) && slot_free && !bus.flush;
  end

  always_ff @(posedge clk or negedge reset) begin : mul_datapath
    if (!reset) begin
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      mul_rd_reg <= '0;
      mul_rw_reg <= 1'b0;
      mul_fe_reg <= 1'b0;
    end else if (accept_mul) begin
      cnt_reg    <= '0;
      mcand_reg  <= {{DATA_W{1'b0}}, op_a};
      acc_reg    <= '0;
      mplier_reg <= op_b;
      mul_rd_reg <= bus.rd;
      mul_rw_reg <= bus.reg_write;
      mul_fe_reg <= bus.flag_en;
    end else if (mul_step) begin
      if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + SH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin : out_register
    if (!reset) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      out_rd_reg    <= '0;
      out_rw_reg    <= 1'b0;
      flags_reg     <= '0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (load_mul) begin
      out_valid_reg <= 1'b1;
      result_reg    <= acc_reg[DATA_W-1:0];
      result_hi_reg <= acc_reg[2*DATA_W-1:DATA_W];
      out_rd_reg    <= mul_rd_reg;
      out_rw_reg    <= mul_rw_reg;
      if (mul_fe_reg)
        flags_reg <= {acc_reg[2*DATA_W-1:DATA_W] != '0, acc_reg[DATA_W-1],
                      acc_reg[DATA_W-1:0] == '0};
    end else if (accept_alu) begin
      out_valid_reg <= 1'b1;
      result_reg    <= alu_res;
      result_hi_reg <= '0;
      out_rd_reg    <= bus.rd;
      out_rw_reg    <= bus.reg_write && !alu_nop;
      if (bus.flag_en && !alu_nop)
        flags_reg <= {alu_c, alu_res[DATA_W-1], alu_res == '0};
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_reg;
  assign bus.result        = result_reg;
  assign bus.result_hi     = result_hi_reg;
  assign bus.out_rd        = out_rd_reg;
  assign bus.out_reg_write = out_rw_reg;
  assign bus.flags         = flags_reg;
endmodule

// File: tb/tb_execute_unit_mc.sv
// Bench for execute_unit_mc: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model built from plain arithmetic.
module tb_execute_unit_mc;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  execute_unit_mc_if #(.DATA_W(DW), .REG_AW(3)) bus ();
  execute_unit_mc #(.DATA_W(DW), .REG_AW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: visible output register plus a countdown for the pending multiply.
  logic          m_valid, m_rw, m_res_known, m_accepted;
  logic [DW-1:0] m_res, m_hi, m_ma, m_mb;
  logic [2:0]    m_rd, m_flags, m_mrd;
  logic          m_mrw, m_mfe;
  int            m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_res_known = 1; m_accepted = 0;
    m_res = '0; m_hi = '0; m_ma = '0; m_mb = '0;
    m_rd = '0; m_flags = '0; m_mrd = '0; m_mrw = 0; m_mfe = 0; m_left = 0;
  endtask

  function automatic logic [DW-1:0] fwd(input logic [2:0] rs, input logic [DW-1:0] src);
    if (m_valid && m_rw && m_rd == rs) return m_res;
    if (bus.wb_reg_write && bus.wb_rd == rs) return bus.wb_data;
    return src;
  endfunction

  task automatic model_edge();
    logic sf, c, nop;
    logic [DW-1:0] a, b, r;
    logic [DW:0] s;
    logic [2*DW-1:0] p;
    int sh;
    sf = !m_valid || bus.out_ready;
    m_accepted = 1'b0;
    if (bus.flush) begin
      m_valid = 0;
      m_left  = 0;
    end else if (m_left == 1) begin
      if (sf) begin
        p = {{DW{1'b0}}, m_ma} * {{DW{1'b0}}, m_mb};
        m_valid = 1; m_res = p[DW-1:0]; m_hi = p[2*DW-1:DW]; m_res_known = 1;
        m_rd = m_mrd; m_rw = m_mrw;
        if (m_mfe) m_flags = {m_hi != 0, m_res[DW-1], m_res == 0};
        m_left = 0;
      end
    end else if (m_left > 1) begin
      m_left--;
      if (bus.out_ready) m_valid = 0;
    end else if (bus.in_valid && sf) begin
      m_accepted = 1;
      a = fwd(bus.rs_a, bus.src_a);
      b = bus.use_imm ? bus.imm : fwd(bus.rs_b, bus.src_b);
      if (bus.op == 4'd10) begin
        m_ma = a; m_mb = b; m_mrd = bus.rd; m_mrw = bus.reg_write; m_mfe = bus.flag_en;
        m_left = DW + 1;
        m_valid = 0;
      end else begin
        r = '0; c = m_flags[2]; nop = 0; sh = int'(bus.shamt); s = '0;
        case (bus.op)
          4'd1:  r = ~a;
          4'd2:  begin s = {1'b0, a} + (DW + 1)'(1); r = s[DW-1:0]; c = s[DW]; end
          4'd3:  begin r = a - DW'(1); c = (a == 0); end
          4'd4:  begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW]; end
          4'd5:  begin r = a - b; c = (a < b); end
          4'd6:  r = a & b;
          4'd7:  r = a | b;
          4'd8:  begin r = a << sh; if (sh != 0) c = a[DW-sh]; end
          4'd9:  begin r = a >> sh; if (sh != 0) c = a[sh-1]; end
          4'd11: r = a;
          default: nop = 1;
        endcase
        m_valid = 1; m_res = r; m_res_known = !nop; m_hi = '0;
        m_rd = bus.rd; m_rw = bus.reg_write && !nop;
        if (bus.flag_en && !nop) m_flags = {c, r[DW-1], r == 0};
      end
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("flags", 32'(bus.flags), 32'(m_flags));
    if (m_valid) begin
      if (m_res_known) check("result", 32'(bus.result), 32'(m_res));
      check("result_hi", 32'(bus.result_hi), 32'(m_hi));
      check("out_rd", 32'(bus.out_rd), 32'(m_rd));
      check("out_reg_write", 32'(bus.out_reg_write), 32'(m_rw));
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(m_left == 0 && (!m_valid || bus.out_ready)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (m_accepted)
      $display("txn t=%0t op=%0d src_a=%h src_b=%h rs_a=%0d rs_b=%0d rd=%0d imm=%0d",
               $time, bus.op, bus.src_a, bus.src_b, bus.rs_a, bus.rs_b, bus.rd, bus.use_imm);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) cycle();
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] d,
                       input logic rw, input logic fe);
    int k;
    bus.in_valid = 1; bus.op = op; bus.src_a = a; bus.src_b = b;
    bus.rs_a = ra; bus.rs_b = rb; bus.rd = d; bus.reg_write = rw; bus.flag_en = fe;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!m_accepted && k < 60);
    bus.in_valid = 0;
    n_cmp++;
    assert (m_accepted) else begin
      n_bad++;
      $error("FAIL accept_timeout: observed no accept expected accept within 60 cycles");
    end
  endtask

  initial begin
    int k;
    bus.in_valid = 0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.rs_a = '0;
    bus.rs_b = '0; bus.use_imm = 0; bus.imm = '0; bus.shamt = '0; bus.rd = '0;
    bus.reg_write = 0; bus.flag_en = 0; bus.flush = 0; bus.wb_rd = '0;
    bus.wb_reg_write = 0; bus.wb_data = '0; bus.out_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1;

    // ADD overflow into the sign bit.
    issue(4'd4, 16'h7FFF, 16'h0001, 3'd1, 3'd2, 3'd3, 1, 1);
    check("t1_result", 32'(bus.result), 32'h8000);
    check("t1_flags", 32'(bus.flags), 32'b010);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);

    // Back-to-back forward from the output register, then a write-back-only forward.
    issue(4'd4, 16'h0010, 16'h0005, 3'd2, 3'd4, 3'd1, 1, 1);
    issue(4'd4, 16'h0000, 16'h0002, 3'd1, 3'd4, 3'd5, 1, 1);
    check("t2_out_fwd", 32'(bus.result), 32'h0017);
    idle(2);
    bus.wb_reg_write = 1; bus.wb_rd = 3'd6; bus.wb_data = 16'h0100;
    issue(4'd4, 16'h0000, 16'h0002, 3'd6, 3'd7, 3'd2, 1, 1);
    check("t2_wb_fwd", 32'(bus.result), 32'h0102);
    bus.wb_reg_write = 0;

    bus.shamt = 4'd1;
    issue(4'd8, 16'h8001, 16'h0000, 3'd0, 3'd0, 3'd4, 1, 1);
    check("shl_result", 32'(bus.result), 32'h0002);
    check("shl_flags", 32'(bus.flags), 32'b100);
    bus.shamt = '0;

    // Multiply latency and result halves.
    idle(1);
    issue(4'd10, 16'h1234, 16'h0100, 3'd0, 3'd0, 3'd2, 1, 1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      cycle();
      k++;
    end
    check("t3_latency", 32'(k), 32'd17);
    check("t3_result", 32'(bus.result), 32'h3400);
    check("t3_result_hi", 32'(bus.result_hi), 32'h0012);
    check("t3_flags", 32'(bus.flags), 32'b100);

    // Output stall holds the SUB result; release lets the waiting ADD issue at once.
    idle(1);
    bus.out_ready = 0;
    issue(4'd5, 16'h0003, 16'h0005, 3'd0, 3'd0, 3'd3, 1, 1);
    bus.in_valid = 1; bus.op = 4'd4; bus.src_a = 16'h0001; bus.src_b = 16'h0001;
    bus.rs_a = 3'd5; bus.rs_b = 3'd5; bus.rd = 3'd4; bus.reg_write = 1; bus.flag_en = 1;
    repeat (3) begin
      cycle();
      check("t4_hold_result", 32'(bus.result), 32'hFFFE);
      check("t4_hold_flags", 32'(bus.flags), 32'b110);
      check("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1;
    cycle();
    bus.in_valid = 0;
    check("t4_no_bubble", 32'(bus.result), 32'h0002);
    check("t4_valid", 32'(bus.out_valid), 32'd1);

    // Flush on the fifth cycle of a multiply.
    issue(4'd10, 16'hFFFF, 16'hFFFF, 3'd6, 3'd7, 3'd5, 1, 1);
    idle(4);
    bus.flush = 1;
    cycle();
    bus.flush = 0;
    #1;
    check("t5_in_ready", 32'(bus.in_ready), 32'd1);
    idle(20);
    check("t5_no_valid", 32'(bus.out_valid), 32'd0);
    check("t5_flags", 32'(bus.flags), 32'b000);

    // Asynchronous reset in the middle of a multiply.
    issue(4'd10, 16'h00FF, 16'h0003, 3'd0, 3'd0, 3'd6, 1, 1);
    idle(5);
    #2 reset = 0;
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_result", 32'(bus.result), 32'd0);
    check("t6_result_hi", 32'(bus.result_hi), 32'd0);
    check("t6_out_rd", 32'(bus.out_rd), 32'd0);
    check("t6_out_reg_write", 32'(bus.out_reg_write), 32'd0);
    check("t6_flags", 32'(bus.flags), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd0);
    #1 reset = 1;
    model_reset();
    @(negedge clk);
    issue(4'd4, 16'h0040, 16'h0002, 3'd0, 3'd0, 3'd1, 1, 1);
    check("t6_after_add", 32'(bus.result), 32'h0042);

    // Random traffic with back-pressure, flushes, immediates and write-back.
    for (int i = 0; i < 800; i++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.op           = 4'($urandom_range(0, 15));
      bus.src_a        = DW'($urandom);
      bus.src_b        = DW'($urandom);
      bus.rs_a         = 3'($urandom_range(0, 7));
      bus.rs_b         = 3'($urandom_range(0, 7));
      bus.use_imm      = ($urandom_range(0, 3) == 0);
      bus.imm          = DW'($urandom);
      bus.shamt        = 4'($urandom_range(0, 15));
      bus.rd           = 3'($urandom_range(0, 7));
      bus.reg_write    = ($urandom_range(0, 3) != 0);
      bus.flag_en      = ($urandom_range(0, 3) != 0);
      bus.flush        = ($urandom_range(0, 40) == 0);
      bus.wb_rd        = 3'($urandom_range(0, 7));
      bus.wb_reg_write = ($urandom_range(0, 1) != 0);
      bus.wb_data      = DW'($urandom);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.flush = 0;
    bus.out_ready = 1;
    idle(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
